// File: rtl/issue_stall_ctrl_if.sv
// Fetch-to-issue handshake plus issued-instruction bus for issue_stall_ctrl.
// Latency: none (wires only).
// Backpressure: in_ready from the controller; hold/flush from downstream.
interface issue_stall_ctrl_if;
    logic [31:0] in_ins;
    logic        in_valid;
    logic        in_ready;
    logic        hold;
    logic        flush;
    logic [31:0] out_ins;
    logic        out_valid;
    logic [15:0] stall_cnt;
    logic [15:0] issue_cnt;

    modport master (
        output in_ins, in_valid, hold, flush,
        input  in_ready, out_ins, out_valid, stall_cnt, issue_cnt
    );

    modport slave (
        input  in_ins, in_valid, hold, flush,
        output in_ready, out_ins, out_valid, stall_cnt, issue_cnt
    );
endinterface

// File: rtl/issue_stall_ctrl.sv
// Buffers fetched instructions and issues one per cycle, inserting one bubble on load-use; counters need ISSUE_STATS_EN.
// Latency: an instruction pushed into an empty FIFO at edge k is on out_ins after edge k+1.
// Backpressure: in_ready = !full from registered count; hold freezes issue, flush empties everything.
module issue_stall_ctrl #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [5:0]  OP_LOAD  = 6'b010100,
    parameter logic [5:0]  OP_STORE = 6'b010101
) (
    input  logic             clk,
    input  logic             reset,
    issue_stall_ctrl_if.slave bus
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [5:0]  op;
        logic [4:0]  dest;
        logic [4:0]  src_a;
        logic [4:0]  src_b;
        logic [10:0] imm_lo;
    } ins_t;

    typedef enum logic [1:0] {IDLE, ISSUE, STALL} state_t;

    ins_t             mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr, rd_ptr;
    logic [CNT_W-1:0] count;
    ins_t             out_q;
    logic             out_vld_q;
    state_t           state, state_nxt;

    ins_t head;
    logic empty, full, push, pop, hazard, reads_src_b, prod_load;

    assign head        = mem[rd_ptr];
    assign empty       = (count == '0);
    assign full        = (count == CNT_W'(DEPTH));
    assign push        = bus.in_valid && !full && !bus.flush;
    assign reads_src_b = !head.op[3] && (head.op != OP_LOAD);
    assign prod_load   = out_vld_q && (out_q.op == OP_LOAD) && (out_q.op != OP_STORE)
                         && (out_q.dest != 5'd0);
    assign hazard      = !empty && prod_load
                         && ((head.src_a == out_q.dest)
                             || (reads_src_b && (head.src_b == out_q.dest)));
    // The bubble drops out_valid, so the held head is free to issue on the STALL exit edge.
    assign pop         = !bus.flush && !bus.hold && !empty && !hazard;

    assign bus.in_ready  = !full;
    assign bus.out_ins   = out_q;
    assign bus.out_valid = out_vld_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= bus.in_ins;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
            if (!bus.hold) begin
                out_q     <= pop ? head : '0;
                out_vld_q <= pop;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        if (bus.flush) begin
            state_nxt = IDLE;
        end else if (!bus.hold) begin
            unique case (state)
                IDLE: begin
                    if (hazard)   state_nxt = STALL;
                    else if (pop) state_nxt = ISSUE;
                end
                ISSUE: begin
                    if (hazard)     state_nxt = STALL;
                    else if (empty) state_nxt = IDLE;
                end
                STALL:   state_nxt = empty ? IDLE : ISSUE;
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef ISSUE_STATS_EN
    logic [15:0] stall_cnt_q, issue_cnt_q;
    logic        stall_ev;

    assign stall_ev = !bus.flush && !bus.hold && hazard;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt_q <= '0;
            issue_cnt_q <= '0;
        end else begin
            if (pop && (issue_cnt_q != 16'hFFFF)) begin
                issue_cnt_q <= issue_cnt_q + 16'd1;
            end
            if (stall_ev && (stall_cnt_q != 16'hFFFF)) begin
                stall_cnt_q <= stall_cnt_q + 16'd1;
            end
        end
    end

    assign bus.stall_cnt = stall_cnt_q;
    assign bus.issue_cnt = issue_cnt_q;
`else
    assign bus.stall_cnt = 16'h0;
    assign bus.issue_cnt = 16'h0;
`endif
endmodule

// File: tb/tb_issue_stall_ctrl.sv
// Directed bench for issue_stall_ctrl: scoreboard of pushed instructions, compared in order on each issue.
module tb_issue_stall_ctrl;
    localparam int DEPTH = 4;

    localparam logic [31:0] I1 = 32'b000000_00001_00010_00011_00000000000;
    localparam logic [31:0] L4 = 32'b010100_00100_00001_00000_00000000000;
    localparam logic [31:0] DP = 32'b000100_00101_00100_00001_00000000000;
    localparam logic [31:0] L0 = 32'b010100_00000_00001_00000_00000000000;
    localparam logic [31:0] R0 = 32'b000000_00111_00000_00000_00000000000;
    localparam logic [31:0] IM = 32'b001101_00110_00001_00100_00000000101;

    logic clk = 1'b0;
    logic reset = 1'b1;

    issue_stall_ctrl_if bus();

    issue_stall_ctrl #(.DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          exp_issue = 0;
    int          exp_stall = 0;
    logic [31:0] sb [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef ISSUE_STATS_EN
        chk({tag, "_issue_cnt"}, 32'(bus.issue_cnt), 32'(exp_issue));
        chk({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'(exp_stall));
`else
        chk({tag, "_issue_cnt"}, 32'(bus.issue_cnt), 32'h0);
        chk({tag, "_stall_cnt"}, 32'(bus.stall_cnt), 32'h0);
`endif
    endtask

    task automatic expect_vld(input string tag, input logic v);
        chk(tag, 32'(bus.out_valid), 32'(v));
    endtask

    // One clock: model acceptance before the edge, then score any fresh issue after it.
    task automatic tick(output logic acc);
        logic hold_e, flush_e;
        acc     = bus.in_valid && !bus.flush && !reset && (sb.size() < DEPTH);
        hold_e  = bus.hold;
        flush_e = bus.flush;
        chk("in_ready", 32'(bus.in_ready), 32'(sb.size() < DEPTH));
        @(posedge clk);
        #1;
        if (flush_e) begin
            sb.delete();
        end else if (!reset) begin
            if (!hold_e && bus.out_valid === 1'b1) begin
                checks++;
                assert (sb.size() != 0) else begin
                    failures++;
                    $error("FAIL issue_unexpected observed=%h expected=none", bus.out_ins);
                end
                if (sb.size() != 0) chk("issue_order", bus.out_ins, sb.pop_front());
                exp_issue++;
            end
            if (acc) sb.push_back(bus.in_ins);
        end
        if (bus.out_valid !== 1'b1) chk("bubble_zero", bus.out_ins, 32'h0);
    endtask

    task automatic step();
        logic a;
        tick(a);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic a;
        int   idx;
        int   guard;
        logic [31:0] f [5];
        for (int i = 0; i < 5; i++) f[i] = {6'b000000, 5'(8 + i), 5'd2, 5'd3, 11'd0};

        bus.in_ins = '0; bus.in_valid = 1'b0; bus.hold = 1'b0; bus.flush = 1'b0;

        // Power-on reset state
        #12;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        expect_vld("rst_out_valid", 1'b0);
        chk("rst_out_ins", bus.out_ins, 32'h0);
        chk_cnt("rst");
        @(posedge clk); #1;
        reset = 1'b0;

        // Basic latency
        bus.in_ins = I1; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        expect_vld("lat_edge_k", 1'b0);
        step();
        expect_vld("lat_edge_k1", 1'b1);
        chk_cnt("first_issue");
        step();
        expect_vld("drain_empty", 1'b0);

        // Load-use: exactly one bubble
        bus.in_ins = L4; bus.in_valid = 1'b1;
        step();
        bus.in_ins = DP;
        step();
        bus.in_valid = 1'b0;
        expect_vld("load_issued", 1'b1);
        step();
        expect_vld("load_use_bubble", 1'b0);
        exp_stall++;
        step();
        expect_vld("dep_issued", 1'b1);
        chk_cnt("load_use");
        step();

        // Load to r0 then reader of r0: no bubble
        bus.in_ins = L0; bus.in_valid = 1'b1;
        step();
        bus.in_ins = R0;
        step();
        bus.in_valid = 1'b0;
        step();
        expect_vld("r0_no_bubble", 1'b1);
        step();

        // Immediate op with srcB field matching load dest: no bubble
        bus.in_ins = L4; bus.in_valid = 1'b1;
        step();
        bus.in_ins = IM;
        step();
        bus.in_valid = 1'b0;
        step();
        expect_vld("imm_no_bubble", 1'b1);
        chk_cnt("no_false_hazard");
        step();

        // Fill under hold, fifth rejected, then ordered drain
        bus.hold = 1'b1;
        idx = 0; guard = 0;
        while (idx < 4 && guard < 20) begin
            bus.in_ins = f[idx]; bus.in_valid = 1'b1;
            tick(a);
            if (a) idx++;
            guard++;
        end
        chk("fill_accepted", 32'(idx), 32'd4);
        bus.in_ins = f[4];
        repeat (2) begin
            step();
            chk("full_in_ready", 32'(bus.in_ready), 32'd0);
            expect_vld("held_no_issue", 1'b0);
        end
        bus.in_valid = 1'b0; bus.hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            expect_vld("drain_consecutive", 1'b1);
        end
        step();
        chk("ready_after_drain", 32'(bus.in_ready), 32'd1);
        expect_vld("drained", 1'b0);
        bus.in_ins = f[4]; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        step();
        expect_vld("fifth_issued", 1'b1);
        step();

        // Flush during STALL with two buffered; push in flush cycle dropped
        bus.in_ins = L4; bus.in_valid = 1'b1;
        step();
        bus.in_ins = DP;
        step();
        bus.in_ins = IM;
        step();
        exp_stall++;
        expect_vld("stall_before_flush", 1'b0);
        bus.in_ins = I1; bus.flush = 1'b1;
        step();
        bus.flush = 1'b0; bus.in_valid = 1'b0;
        expect_vld("flush_out_valid", 1'b0);
        chk("flush_in_ready", 32'(bus.in_ready), 32'd1);
        step();
        expect_vld("flush_emptied", 1'b0);
        chk_cnt("flush_keeps_counters");
        bus.in_ins = R0; bus.in_valid = 1'b1;
        step();
        bus.in_valid = 1'b0;
        expect_vld("post_flush_lat_k", 1'b0);
        step();
        expect_vld("post_flush_lat_k1", 1'b1);

        // Reset mid-stream with three buffered
        bus.hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_ins = f[i]; bus.in_valid = 1'b1;
            step();
        end
        bus.in_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(bus.in_ready), 32'd1);
        expect_vld("midrst_out_valid", 1'b0);
        chk("midrst_out_ins", bus.out_ins, 32'h0);
        chk("midrst_issue_cnt", 32'(bus.issue_cnt), 32'h0);
        chk("midrst_stall_cnt", 32'(bus.stall_cnt), 32'h0);
        sb.delete();
        exp_issue = 0; exp_stall = 0;
        @(posedge clk); #1;
        reset = 1'b0; bus.hold = 1'b0;
        step();
        expect_vld("no_partial_issue", 1'b0);
        step();
        expect_vld("still_empty", 1'b0);
        chk_cnt("after_midrst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
